// File: rtl/mem_wb_elastic_pkg.sv
// Shared definitions for the MEM/WB elastic stage: reset level, write-enable
// levels, zero/NOP constants, and the two-entry skid buffer state encoding.
package mem_wb_elastic_pkg;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic logic [1:0] occupancy_of(input skid_state_e s);
    return s;
  endfunction

endpackage

// File: rtl/mem_wb_elastic_skid2.sv
// Payload-agnostic two-entry elastic buffer (main + skid).
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid never depends on ready, and in_ready depends only on registered
// state, so there is no combinational path from out_ready to in_ready.
import mem_wb_elastic_pkg::*;

module pipe_skid2 #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output skid_state_e          state_dbg
);

  skid_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, skid_q;
  logic                 in_fire, out_fire;
  logic                 ld_main_in, ld_main_skid, ld_skid_in;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  // An empty buffer presents an all-zero payload, i.e. a NOP bubble.
  assign out_data  = out_valid ? main_q : '0;
  assign state_dbg = state_q;

  // Next-state and entry-load decisions; flush overrides both handshakes.
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid_in   = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            ld_main_in = 1'b1;
            state_d    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            ld_skid_in = 1'b1;
            state_d    = ST_FULL;
          end else if (in_fire && out_fire) begin
            ld_main_in = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            ld_main_skid = 1'b1;
            state_d      = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state_q <= ST_EMPTY;
    else                   state_q <= state_d;
  end

  // Entry storage; reset and flush both clear held payloads.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)        main_q <= in_data;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid_in)        skid_q <= in_data;
    end
  end

endmodule

// File: rtl/mem_wb_elastic.sv
// MEM/WB elastic pipeline register: packs the MEM-stage writeback bundle
// (GPR ports, HI/LO, LLbit) into one payload word carried through a
// two-entry skid buffer, then unpacks it onto the wb_* outputs.
// With two write ports, port 0 occupies the LSBs of each packed field and
// both ports travel in the same entry; same-address writes are passed through
// untouched (port 1 is the younger write).
import mem_wb_elastic_pkg::*;

module mem_wb_elastic #(
  parameter int DATA_W = 32,
  parameter int NUM_WP = 1,
  parameter int REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_WP*REG_AW-1:0] mem_wd,
  input  logic [NUM_WP-1:0]        mem_wreg,
  input  logic [NUM_WP*DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0]        mem_hi,
  input  logic [DATA_W-1:0]        mem_lo,
  input  logic                     mem_whilo,
  input  logic                     mem_LLbit_we,
  input  logic                     mem_LLbit_value,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [NUM_WP*REG_AW-1:0] wb_wd,
  output logic [NUM_WP-1:0]        wb_wreg,
  output logic [NUM_WP*DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0]        wb_hi,
  output logic [DATA_W-1:0]        wb_lo,
  output logic                     wb_whilo,
  output logic                     wb_LLbit_we,
  output logic                     wb_LLbit_value,
  output logic [1:0]               occupancy
);

  localparam int PAYLOAD_W = NUM_WP * (REG_AW + 1 + DATA_W) + 2 * DATA_W + 3;

  if (NUM_WP != 1 && NUM_WP != 2) begin : g_bad_num_wp
    $error("mem_wb_elastic: NUM_WP must be 1 or 2");
  end

  logic [PAYLOAD_W-1:0] in_payload, out_payload;
  skid_state_e          skid_state;

  assign in_payload = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo,
                       mem_whilo, mem_LLbit_we, mem_LLbit_value};

  assign {wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo,
          wb_whilo, wb_LLbit_we, wb_LLbit_value} = out_payload;

  assign occupancy = occupancy_of(skid_state);

  pipe_skid2 #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_payload),
    .out_valid(wb_valid),
    .out_ready(wb_ready),
    .out_data (out_payload),
    .state_dbg(skid_state)
  );

endmodule

// File: doc/mem_wb_elastic.md
MEM_WB_ELASTIC -- requirements
Module: mem_wb_elastic

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register/HI/LO data width.
REQ-002 SHALL have parameter NUM_WP, default 1, meaning the number of GPR write ports; legal values are 1 and 2.
REQ-003 SHALL have parameter REG_AW, default 5, meaning GPR address width.
REQ-004 SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-005 SHALL have ports: clk input 1, the rising-edge clock; rst input 1, the synchronous active-high reset.
REQ-006 SHALL have ports: flush input 1, discard all held entries; in_valid input 1; in_ready output 1.
REQ-007 SHALL have GPR input ports: mem_wd input NUM_WP*REG_AW; mem_wreg input NUM_WP; mem_wdata input NUM_WP*DATA_W.
REQ-008 SHALL have HI/LO and LLbit input ports: mem_hi input DATA_W; mem_lo input DATA_W; mem_whilo input 1; mem_LLbit_we input 1; mem_LLbit_value input 1.
REQ-009 SHALL have output-side ports: wb_valid output 1; wb_ready input 1; wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo, wb_LLbit_we, wb_LLbit_value as outputs, each the same width as its mem_* input.
REQ-010 SHALL have port occupancy output 2, giving the number of held entries (0..2).

Function
REQ-011 in_fire = in_valid & in_ready; out_fire = wb_valid & wb_ready.
REQ-012 The block SHALL hold a 2-entry elastic buffer with a main entry (drives wb_*) and a skid entry, controlled by states EMPTY, ONE and FULL.
REQ-013 EMPTY SHALL behave as follows: on in_fire, main<=input and go to ONE; otherwise stay in EMPTY.
REQ-014 ONE, in_fire & !out_fire: skid<=input and go to FULL.
REQ-015 ONE, in_fire & out_fire: main<=input and stay in ONE.
REQ-016 ONE, !in_fire & out_fire: go to EMPTY; with neither event, hold.
REQ-017 FULL, out_fire: main<=skid and go to ONE; with no out_fire, hold.
REQ-018 in_ready SHALL equal (state != FULL) and SHALL be a function of registered state only; there SHALL be no combinational path from wb_ready to in_ready.
REQ-019 wb_valid SHALL equal (state != EMPTY); latency from in_fire to wb_valid SHALL be 1 cycle; sustained throughput SHALL be 1 entry/cycle while wb_ready=1.
REQ-020 When wb_valid=0, all wb_* payload outputs SHALL read zero, so that wb_wreg, wb_whilo and wb_LLbit_we are write-disabled as a NOP bubble.
REQ-021 While wb_valid=1 & wb_ready=0, all wb_* outputs SHALL hold stable.
REQ-022 Entries SHALL be delivered in arrival order; no entry SHALL be dropped or duplicated except under flush or rst.
REQ-023 flush=1 SHALL empty both entries and go to EMPTY next cycle, overriding in_fire and out_fire in the same cycle; input presented with flush SHALL be discarded.
REQ-024 With NUM_WP=2, ports SHALL be packed with port 0 in the LSBs; both ports SHALL be carried atomically in one entry.
REQ-025 Write-port ordering for NUM_WP=2 SHALL be: if both ports write the same address, port 1 is the younger write; the block SHALL pass both unchanged without arbitration.
REQ-026 occupancy SHALL read 0, 1 or 2 for EMPTY, ONE or FULL respectively.

Reset
REQ-027 rst=1 at a rising edge SHALL force state EMPTY and zero both entries, giving wb_valid=0, in_ready=1, occupancy=0 and all wb_* = 0.
REQ-028 rst SHALL take priority over flush and all handshakes, including a reset asserted mid-burst while FULL.

Structure
REQ-029 Reset level, write enable/disable, zero word and NOP register address constants SHALL come from the shared defines file; no local redefinition SHALL be made.
REQ-030 A payload-agnostic sub-module pipe_skid2 (parameter PAYLOAD_W) SHALL implement REQ-012..REQ-023; mem_wb_elastic SHALL only pack and unpack the payload.
REQ-031 Elaboration SHALL fail when NUM_WP is not 1 or 2.

Verification
REQ-032 Reset scenario: rst for 2 cycles, then release -> wb_valid=0, in_ready=1, occupancy=0, all wb_* = 0.
REQ-033 Streaming scenario: wb_ready=1 held, 4 back-to-back entries with wdata 0x11..0x44, wd 1..4 -> each appears 1 cycle after its in_fire, in order, and in_ready stays 1.
REQ-034 Backpressure scenario: wb_ready=0, send A=0xA0 and B=0xB0 -> occupancy=2 and in_ready=0 with wb_wdata holding 0xA0; raise wb_ready -> A then B, no loss.
REQ-035 Flush scenario: while FULL, assert flush together with in_valid for C=0xC0 -> next cycle wb_valid=0, occupancy=0, and C is never output.
REQ-036 NUM_WP=2 scenario: wd={5,5}, wreg=2'b11, wdata={0x2,0x1} -> wb_* carry both ports unchanged in a single beat.
REQ-037 Mid-operation reset scenario: rst asserted while FULL with wb_ready=0 -> next cycle all outputs are at reset values and no stale entry appears afterwards.
